// File: rtl/cordic_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_arb_pkg
// Description : Shared types and default sizes for the CORDIC stream arbiter.
//               arb_state_t : inbound arbitration FSM states
//               req_id_t    : requester id carried in the tag FIFO
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_arb_pkg;

  localparam int REQ_TDATA_WIDTH_DFLT = 32;
  localparam int RES_TDATA_WIDTH_DFLT = 64;
  localparam int TAG_DEPTH_DFLT       = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/cordic_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cordic_tag_fifo
// Description : TAG_DEPTH x 1-bit FIFO holding the owner of every beat issued
//               to the CORDIC. Head is the owner of the oldest beat in flight.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               push, push_id- write one owner id (ignored when full)
//               pop          - drop the head entry (ignored when empty)
//               full, empty  - occupancy flags
//               head         - owner id of the oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_tag_fifo
  import cordic_arb_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DFLT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output req_id_t head
);

  // TAG_DEPTH is a power of two (>= 2), so pointers wrap by natural overflow.
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  req_id_t          r_mem [TAG_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign full  = (r_count == CNT_W'(TAG_DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_stream_arbiter
// Description : Shares one pipelined CORDIC between two AXI-Stream requesters.
//               Inbound: packet-locked round-robin, combinational data path.
//               Outbound: results routed in order to the owner recorded in a
//               tag FIFO at issue time.
// Ports       : s00_axis_aclk/aresetn - clock, asynchronous active-low reset
//               s00_axis_*, s01_axis_* - requester 0/1 samples in
//               m00_axis_*             - muxed samples to the CORDIC
//               s02_axis_*             - results from the CORDIC
//               m01_axis_*, m02_axis_* - results to requester 0/1
//               err_orphan             - sticky, result seen with no tag
//               pkt_cnt0/1             - packets issued per requester
//                                        (only with CORDIC_ARB_STATS_EN)
// Options     : CORDIC_ARB_STATS_EN - adds the per-requester packet counters
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_stream_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int C_REQ_TDATA_WIDTH = REQ_TDATA_WIDTH_DFLT,
  parameter int C_RES_TDATA_WIDTH = RES_TDATA_WIDTH_DFLT,
  parameter int TAG_DEPTH         = TAG_DEPTH_DFLT
) (
  input  logic                         s00_axis_aclk,
  input  logic                         s00_axis_aresetn,
  input  logic                         s00_axis_tvalid,
  output logic                         s00_axis_tready,
  input  logic                         s00_axis_tlast,
  input  logic [C_REQ_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                         s01_axis_tvalid,
  output logic                         s01_axis_tready,
  input  logic                         s01_axis_tlast,
  input  logic [C_REQ_TDATA_WIDTH-1:0] s01_axis_tdata,
  output logic                         m00_axis_tvalid,
  input  logic                         m00_axis_tready,
  output logic                         m00_axis_tlast,
  output logic [C_REQ_TDATA_WIDTH-1:0] m00_axis_tdata,
  input  logic                         s02_axis_tvalid,
  output logic                         s02_axis_tready,
  input  logic                         s02_axis_tlast,
  input  logic [C_RES_TDATA_WIDTH-1:0] s02_axis_tdata,
  output logic                         m01_axis_tvalid,
  input  logic                         m01_axis_tready,
  output logic                         m01_axis_tlast,
  output logic [C_RES_TDATA_WIDTH-1:0] m01_axis_tdata,
  output logic                         m02_axis_tvalid,
  input  logic                         m02_axis_tready,
  output logic                         m02_axis_tlast,
  output logic [C_RES_TDATA_WIDTH-1:0] m02_axis_tdata,
`ifdef CORDIC_ARB_STATS_EN
  output logic [31:0]                  pkt_cnt0,
  output logic [31:0]                  pkt_cnt1,
`endif
  output logic                         err_orphan
);

  logic clk;
  logic rst_n;
  assign clk   = s00_axis_aclk;
  assign rst_n = s00_axis_aresetn;

  arb_state_t r_state;
  arb_state_t w_state_next;
  req_id_t    r_rr_pref;       // requester that wins the next contention
  req_id_t    w_rr_pref_next;

  logic    w_grant0;
  logic    w_grant1;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  req_id_t w_fifo_head;
  logic    w_issue;            // beat accepted by the CORDIC
  logic    w_retire;           // result accepted from the CORDIC
  logic    r_err_orphan;

  // --------------------------------------------------------------------------
  // Arbitration FSM. A request seen in IDLE is granted on the next cycle, and
  // the grant is held until the tlast beat is accepted on m00.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_pref <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rr_pref <= w_rr_pref_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_rr_pref_next = r_rr_pref;
    case (r_state)
      IDLE: begin
        if (s00_axis_tvalid && s01_axis_tvalid) begin
          w_state_next   = r_rr_pref ? GRANT1 : GRANT0;
          w_rr_pref_next = ~r_rr_pref;
        end else if (s00_axis_tvalid) begin
          w_state_next = GRANT0;
        end else if (s01_axis_tvalid) begin
          w_state_next = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (w_issue && m00_axis_tlast) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_grant0 = (r_state == GRANT0);
  assign w_grant1 = (r_state == GRANT1);

  // --------------------------------------------------------------------------
  // Inbound path: pure mux, stalled while the tag FIFO cannot record an owner.
  // --------------------------------------------------------------------------
  assign m00_axis_tvalid = ((w_grant0 & s00_axis_tvalid) | (w_grant1 & s01_axis_tvalid))
                           & ~w_fifo_full;
  assign m00_axis_tdata  = w_grant1 ? s01_axis_tdata : s00_axis_tdata;
  assign m00_axis_tlast  = w_grant1 ? s01_axis_tlast : s00_axis_tlast;
  assign s00_axis_tready = m00_axis_tready & w_grant0 & ~w_fifo_full;
  assign s01_axis_tready = m00_axis_tready & w_grant1 & ~w_fifo_full;

  assign w_issue = m00_axis_tvalid & m00_axis_tready;

  cordic_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_issue),
    .push_id (w_grant1),
    .pop     (w_retire),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .head    (w_fifo_head)
  );

  // --------------------------------------------------------------------------
  // Return path: strictly in order, so a stalled owner blocks the other one.
  // --------------------------------------------------------------------------
  assign m01_axis_tvalid = s02_axis_tvalid & ~w_fifo_empty & ~w_fifo_head;
  assign m02_axis_tvalid = s02_axis_tvalid & ~w_fifo_empty &  w_fifo_head;
  assign m01_axis_tdata  = s02_axis_tdata;
  assign m02_axis_tdata  = s02_axis_tdata;
  assign m01_axis_tlast  = s02_axis_tlast;
  assign m02_axis_tlast  = s02_axis_tlast;
  assign s02_axis_tready = (w_fifo_head ? m02_axis_tready : m01_axis_tready) & ~w_fifo_empty;

  assign w_retire = s02_axis_tvalid & s02_axis_tready;

  // A result with no outstanding tag cannot be routed; flag it and leave it
  // unacknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_orphan <= 1'b0;
    end else if (s02_axis_tvalid && w_fifo_empty) begin
      r_err_orphan <= 1'b1;
    end
  end

  assign err_orphan = r_err_orphan;

`ifdef CORDIC_ARB_STATS_EN
  logic [31:0] r_pkt_cnt0;
  logic [31:0] r_pkt_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else if (w_issue && m00_axis_tlast) begin
      if (w_grant1) begin
        r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
      end else begin
        r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
      end
    end
  end

  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_stream_arbiter
// Description : Self-checking bench for cordic_stream_arbiter. Two requester
//               drivers and a fixed-latency CORDIC model run on the falling
//               edge; directed steps run in one initial block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_stream_arbiter;
  import cordic_arb_pkg::*;

  localparam int TAG_DEPTH = 4;
  localparam int LAT       = 8;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        owner;
  } exp_beat_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        owner;
  } exp_res_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          due;
  } pipe_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s00_axis_tvalid, s00_axis_tready, s00_axis_tlast;
  logic [31:0] s00_axis_tdata;
  logic        s01_axis_tvalid, s01_axis_tready, s01_axis_tlast;
  logic [31:0] s01_axis_tdata;
  logic        m00_axis_tvalid, m00_axis_tready, m00_axis_tlast;
  logic [31:0] m00_axis_tdata;
  logic        s02_axis_tvalid, s02_axis_tready, s02_axis_tlast;
  logic [63:0] s02_axis_tdata;
  logic        m01_axis_tvalid, m01_axis_tready, m01_axis_tlast;
  logic [63:0] m01_axis_tdata;
  logic        m02_axis_tvalid, m02_axis_tready, m02_axis_tlast;
  logic [63:0] m02_axis_tdata;
  logic        err_orphan;
`ifdef CORDIC_ARB_STATS_EN
  logic [31:0] pkt_cnt0, pkt_cnt1;
`endif

  cordic_stream_arbiter #(
    .C_REQ_TDATA_WIDTH (32),
    .C_RES_TDATA_WIDTH (64),
    .TAG_DEPTH         (TAG_DEPTH)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s00_axis_tvalid),
    .s00_axis_tready  (s00_axis_tready),
    .s00_axis_tlast   (s00_axis_tlast),
    .s00_axis_tdata   (s00_axis_tdata),
    .s01_axis_tvalid  (s01_axis_tvalid),
    .s01_axis_tready  (s01_axis_tready),
    .s01_axis_tlast   (s01_axis_tlast),
    .s01_axis_tdata   (s01_axis_tdata),
    .m00_axis_tvalid  (m00_axis_tvalid),
    .m00_axis_tready  (m00_axis_tready),
    .m00_axis_tlast   (m00_axis_tlast),
    .m00_axis_tdata   (m00_axis_tdata),
    .s02_axis_tvalid  (s02_axis_tvalid),
    .s02_axis_tready  (s02_axis_tready),
    .s02_axis_tlast   (s02_axis_tlast),
    .s02_axis_tdata   (s02_axis_tdata),
    .m01_axis_tvalid  (m01_axis_tvalid),
    .m01_axis_tready  (m01_axis_tready),
    .m01_axis_tlast   (m01_axis_tlast),
    .m01_axis_tdata   (m01_axis_tdata),
    .m02_axis_tvalid  (m02_axis_tvalid),
    .m02_axis_tready  (m02_axis_tready),
    .m02_axis_tlast   (m02_axis_tlast),
    .m02_axis_tdata   (m02_axis_tdata),
`ifdef CORDIC_ARB_STATS_EN
    .pkt_cnt0         (pkt_cnt0),
    .pkt_cnt1         (pkt_cnt1),
`endif
    .err_orphan       (err_orphan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_issued = 0;
  int n_ret0   = 0;
  int n_ret1   = 0;
  bit saw_m02  = 0;
  bit cordic_en    = 1;
  int credit       = 0;
  bit orphan_force = 0;

  beat_t     q0[$];
  beat_t     q1[$];
  exp_beat_t exp_m00[$];
  exp_res_t  exp_ret[$];
  pipe_t     pipe[$];

  function automatic logic [63:0] cordic_f(input logic [31:0] x);
    return {x ^ 32'h5A5A_0000, x + 32'h0000_1000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one beat on a requester and record where it must appear on m00.
  task automatic push_beat(input logic owner, input logic [31:0] d, input logic l);
    beat_t     b;
    exp_beat_t e;
    b.data = d; b.last = l;
    e.data = d; e.last = l; e.owner = owner;
    if (owner) q1.push_back(b);
    else       q0.push_back(b);
    exp_m00.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((q0.size() + q1.size() + exp_m00.size() + exp_ret.size() + pipe.size()) > 0
           && k < 500) begin
      tick(1);
      k++;
    end
    check(tag, 64'(k < 500), 64'd1);
  endtask

  task automatic wait_issued(input string tag, input int base, input int n);
    int k = 0;
    while ((n_issued - base) < n && k < 200) begin
      tick(1);
      k++;
    end
    check(tag, 64'(k < 200), 64'd1);
  endtask

  // --------------------------------------------------------------------------
  // Requester drivers, CORDIC model and output scoreboard. Inputs change on
  // the falling edge; handshakes are evaluated once they have settled.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_beat_t e;
    exp_res_t  r;
    pipe_t     p;
    cyc++;
    s00_axis_tvalid = (q0.size() > 0);
    s00_axis_tdata  = (q0.size() > 0) ? q0[0].data : 32'd0;
    s00_axis_tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    s01_axis_tvalid = (q1.size() > 0);
    s01_axis_tdata  = (q1.size() > 0) ? q1[0].data : 32'd0;
    s01_axis_tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
    if (orphan_force) begin
      s02_axis_tvalid = 1'b1;
      s02_axis_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
      s02_axis_tlast  = 1'b1;
    end else if (pipe.size() > 0 && pipe[0].due <= cyc && (cordic_en || credit > 0)) begin
      s02_axis_tvalid = 1'b1;
      s02_axis_tdata  = pipe[0].data;
      s02_axis_tlast  = pipe[0].last;
    end else begin
      s02_axis_tvalid = 1'b0;
      s02_axis_tdata  = 64'd0;
      s02_axis_tlast  = 1'b0;
    end
    #1;
    if (s00_axis_tvalid && s00_axis_tready) void'(q0.pop_front());
    if (s01_axis_tvalid && s01_axis_tready) void'(q1.pop_front());
    if (m00_axis_tvalid && m00_axis_tready) begin
      n_issued++;
      check("m00_expected_beat", 64'(exp_m00.size() > 0), 64'd1);
      if (exp_m00.size() > 0) begin
        e = exp_m00.pop_front();
        check("m00_tdata", 64'(m00_axis_tdata), 64'(e.data));
        check("m00_tlast", 64'(m00_axis_tlast), 64'(e.last));
        r.data = cordic_f(e.data); r.last = e.last; r.owner = e.owner;
        exp_ret.push_back(r);
      end
      p.data = cordic_f(m00_axis_tdata); p.last = m00_axis_tlast; p.due = cyc + LAT;
      pipe.push_back(p);
    end
    if (s02_axis_tvalid && s02_axis_tready) begin
      if (!orphan_force && pipe.size() > 0) void'(pipe.pop_front());
      if (credit > 0) credit--;
    end
    if (m01_axis_tvalid || m02_axis_tvalid)
      check("ret_onehot", 64'(m01_axis_tvalid & m02_axis_tvalid), 64'd0);
    if (m02_axis_tvalid) saw_m02 = 1'b1;
    if ((m01_axis_tvalid && m01_axis_tready) || (m02_axis_tvalid && m02_axis_tready)) begin
      check("ret_expected", 64'(exp_ret.size() > 0), 64'd1);
      if (exp_ret.size() > 0) begin
        r = exp_ret.pop_front();
        check("ret_owner", 64'(m02_axis_tvalid), 64'(r.owner));
        check("ret_tdata", m02_axis_tvalid ? m02_axis_tdata : m01_axis_tdata, r.data);
        check("ret_tlast", 64'(m02_axis_tvalid ? m02_axis_tlast : m01_axis_tlast), 64'(r.last));
      end
      if (m02_axis_tvalid) n_ret1++;
      else                 n_ret0++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed steps
  // --------------------------------------------------------------------------
  initial begin
    int base;
    int base0;
    int base1;
    rst_n           = 1'b0;
    m00_axis_tready = 1'b1;
    m01_axis_tready = 1'b1;
    m02_axis_tready = 1'b1;

    // Contention right after reset: s00 wins, then the pointer alternates.
    for (int i = 1; i <= 3; i++) push_beat(1'b0, 32'(i), i == 3);
    for (int i = 1; i <= 3; i++) push_beat(1'b1, 32'h100 + 32'(i), i == 3);
    for (int i = 4; i <= 6; i++) push_beat(1'b0, 32'(i), i == 6);
    for (int i = 4; i <= 6; i++) push_beat(1'b1, 32'h100 + 32'(i), i == 6);

    // Reset state with both requesters asserting tvalid.
    tick(3);
    check("rst_m00_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("rst_s00_tready", 64'(s00_axis_tready), 64'd0);
    check("rst_s01_tready", 64'(s01_axis_tready), 64'd0);
    check("rst_s02_tready", 64'(s02_axis_tready), 64'd0);
    check("rst_m01_tvalid", 64'(m01_axis_tvalid), 64'd0);
    check("rst_m02_tvalid", 64'(m02_axis_tvalid), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);

    rst_n = 1'b1;
    #1;
    check("bubble_m00_tvalid", 64'(m00_axis_tvalid), 64'd0);
    tick(1);
    check("grant0_m00_tvalid", 64'(m00_axis_tvalid), 64'd1);
    check("grant0_m00_tdata", 64'(m00_axis_tdata), 64'd1);
    check("grant0_s01_tready", 64'(s01_axis_tready), 64'd0);
    wait_drain("contention_drain");

    // Single 4-beat packet from s00 only.
    saw_m02 = 1'b0;
    base0   = n_ret0;
    for (int i = 1; i <= 4; i++) push_beat(1'b0, 32'(i), i == 4);
    wait_drain("single_drain");
    check("single_m02_quiet", 64'(saw_m02), 64'd0);
    check("single_m01_count", 64'(n_ret0 - base0), 64'd4);

    // s01 arrives during a 5-beat s00 packet and must wait for its tlast.
    base = n_issued;
    for (int i = 1; i <= 5; i++) push_beat(1'b0, 32'h30 + 32'(i), i == 5);
    wait_issued("lock_wait", base, 1);
    push_beat(1'b1, 32'h131, 1'b0);
    push_beat(1'b1, 32'h132, 1'b1);
    tick(1);
    check("lock_s01_tready", 64'(s01_axis_tready), 64'd0);
    wait_drain("lock_drain");

    // Tag FIFO full with the CORDIC holding back results.
    cordic_en = 1'b0;
    base      = n_issued;
    for (int i = 1; i <= 6; i++) push_beat(1'b0, 32'h40 + 32'(i), i == 6);
    tick(15);
    check("full_issued", 64'(n_issued - base), 64'd4);
    check("full_m00_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("full_s00_tready", 64'(s00_axis_tready), 64'd0);
    credit = 1;
    tick(8);
    check("full_one_more", 64'(n_issued - base), 64'd5);
    cordic_en = 1'b1;
    wait_drain("full_drain");

    // Head-of-line blocking: head owner 0 stalled, owner 1 behind it.
    m01_axis_tready = 1'b0;
    base0 = n_ret0;
    base1 = n_ret1;
    push_beat(1'b0, 32'h51, 1'b1);
    tick(3);
    push_beat(1'b1, 32'h151, 1'b1);
    tick(20);
    check("hol_s02_tready", 64'(s02_axis_tready), 64'd0);
    check("hol_m01_tvalid", 64'(m01_axis_tvalid), 64'd1);
    check("hol_m02_tvalid", 64'(m02_axis_tvalid), 64'd0);
    check("hol_m02_count", 64'(n_ret1 - base1), 64'd0);
    m01_axis_tready = 1'b1;
    wait_drain("hol_drain");
    check("hol_m01_after", 64'(n_ret0 - base0), 64'd1);
    check("hol_m02_after", 64'(n_ret1 - base1), 64'd1);

    // Reset in the middle of a packet, then a result with no tag.
    base = n_issued;
    for (int i = 1; i <= 4; i++) push_beat(1'b0, 32'h60 + 32'(i), i == 4);
    wait_issued("midrst_wait", base, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_m00_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("midrst_s00_tready", 64'(s00_axis_tready), 64'd0);
    check("midrst_s02_tready", 64'(s02_axis_tready), 64'd0);
    check("midrst_state", 64'(dut.r_state), 64'(IDLE));
    q0.delete();
    exp_m00.delete();
    exp_ret.delete();
    pipe.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    orphan_force = 1'b1;
    tick(2);
    check("orphan_set", 64'(err_orphan), 64'd1);
    check("orphan_s02_tready", 64'(s02_axis_tready), 64'd0);
    check("orphan_m01_tvalid", 64'(m01_axis_tvalid), 64'd0);
    orphan_force = 1'b0;
    tick(4);
    check("orphan_sticky", 64'(err_orphan), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
